// File: rtl/carry_timer.sv
// Programmable down-counting timer: prescaler, one-shot/periodic modes, sticky irq/ovr.
// The decrement path is an explicit SB_LUT4 + SB_CARRY ripple chain (one LUT and one carry per bit).

module SB_LUT4 #(
  parameter logic [15:0] LUT_INIT = 16'h0000
) (
  output logic O,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3
);
  assign O = LUT_INIT[{I3, I2, I1, I0}];
endmodule

module SB_CARRY (
  output logic CO,
  input  logic I0,
  input  logic I1,
  input  logic CI
);
  assign CO = (I0 & I1) | (I0 & CI) | (I1 & CI);
endmodule

module carry_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  C,
  input  logic                  R_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  irq_ack,
  output logic [WIDTH-1:0]      cnt,
  output logic                  busy,
  output logic                  tick,
  output logic                  irq,
  output logic                  ovr
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state, w_state_next;
  logic [WIDTH-1:0]      r_cnt, w_cnt_next;
  logic [WIDTH-1:0]      r_reload, w_reload_next;
  logic [PRESCALE_W-1:0] r_pre, w_pre_next;
  logic                  r_busy, w_busy_next;
  logic                  r_tick, w_tick_next;
  logic                  r_irq, w_irq_next;
  logic                  r_ovr, w_ovr_next;

  logic [WIDTH-1:0]      w_dec;
  logic [WIDTH:0]        w_ci;
  logic                  w_step;
  logic                  w_expire;

  // cnt + all-ones; the LUT computes I1 ^ I2 ^ I3 with I1=cnt, I2=1, I3=carry-in.
  assign w_ci[0] = 1'b0;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
    SB_LUT4 #(.LUT_INIT(16'hC33C)) u_lut (
      .O  (w_dec[gi]),
      .I0 (1'b0),
      .I1 (r_cnt[gi]),
      .I2 (1'b1),
      .I3 (w_ci[gi])
    );
    SB_CARRY u_carry (
      .CO (w_ci[gi+1]),
      .I0 (r_cnt[gi]),
      .I1 (1'b1),
      .CI (w_ci[gi])
    );
  end

  assign w_step   = (r_state == S_RUN) && en && (r_pre == prescale);
  assign w_expire = w_step && (r_cnt == WIDTH'(1));

  // State register
  always_ff @(posedge C or negedge R_n) begin
    if (!R_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_reload <= '0;
      r_pre    <= '0;
      r_busy   <= 1'b0;
      r_tick   <= 1'b0;
      r_irq    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_reload <= w_reload_next;
      r_pre    <= w_pre_next;
      r_busy   <= w_busy_next;
      r_tick   <= w_tick_next;
      r_irq    <= w_irq_next;
      r_ovr    <= w_ovr_next;
    end
  end

  // Next-state logic; load outranks any step or expiry in the same cycle.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_reload_next = r_reload;
    w_pre_next    = r_pre;
    w_tick_next   = 1'b0;
    w_irq_next    = irq_ack ? 1'b0 : r_irq;
    w_ovr_next    = irq_ack ? 1'b0 : r_ovr;

    if (load) begin
      w_reload_next = load_val;
      w_cnt_next    = load_val;
      w_pre_next    = '0;
      w_state_next  = (load_val != '0) ? S_RUN : S_IDLE;
    end else if (r_state == S_RUN && en) begin
      if (w_step) begin
        w_pre_next = '0;
        if (w_expire) begin
          w_tick_next = 1'b1;
          w_irq_next  = 1'b1;
          if (r_irq && !irq_ack) w_ovr_next = 1'b1;
          if (mode) begin
            w_cnt_next = r_reload;
          end else begin
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
          end
        end else if (w_ci[WIDTH]) begin
          // Carry-out of cnt + all-ones is set exactly when cnt is non-zero.
          w_cnt_next = w_dec;
        end
      end else begin
        w_pre_next = r_pre + PRESCALE_W'(1);
      end
    end

    w_busy_next = (w_state_next == S_RUN);
  end

  // Outputs are taken straight from flops
  assign cnt  = r_cnt;
  assign busy = r_busy;
  assign tick = r_tick;
  assign irq  = r_irq;
  assign ovr  = r_ovr;

endmodule

// File: tb/tb_carry_timer.sv
// Self-checking bench for carry_timer: a behavioural reference pushes expected outputs
// into a queue as each cycle's stimulus is driven; they are popped and compared after the edge.

module tb_carry_timer;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          C = 1'b0;
  logic          R_n = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          mode = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          irq_ack = 1'b0;
  logic [W-1:0]  cnt;
  logic          busy, tick, irq, ovr;

  carry_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .C        (C),
    .R_n      (R_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .prescale (prescale),
    .irq_ack  (irq_ack),
    .cnt      (cnt),
    .busy     (busy),
    .tick     (tick),
    .irq      (irq),
    .ovr      (ovr)
  );

  always #5 C = ~C;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic         tick;
    logic         irq;
    logic         ovr;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int tick_seen = 0;
  int tick_at[$];

  // Reference model state
  logic [W-1:0]  m_cnt = '0, m_reload = '0;
  logic [PW-1:0] m_pre = '0;
  logic          m_run = 0, m_tick = 0, m_irq = 0, m_ovr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_reload = '0; m_pre = '0;
    m_run = 0; m_tick = 0; m_irq = 0; m_ovr = 0;
  endtask

  task automatic model_step(input logic ld, input logic [W-1:0] lv, input logic md,
                            input logic [PW-1:0] ps, input logic e, input logic ack);
    logic expire;
    expire = 0;
    m_tick = 0;
    if (ld) begin
      m_reload = lv; m_cnt = lv; m_pre = '0; m_run = (lv != 0);
    end else if (m_run && e) begin
      if (m_pre == ps) begin
        m_pre = '0;
        if (m_cnt == 1) expire = 1;
        else m_cnt = m_cnt - 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (expire) begin
      m_tick = 1;
      m_ovr  = ack ? 1'b0 : (m_irq ? 1'b1 : m_ovr);
      m_irq  = 1;
      if (md) m_cnt = m_reload;
      else begin m_cnt = '0; m_run = 0; end
    end else if (ack) begin
      m_irq = 0; m_ovr = 0;
    end
  endtask

  // One clock cycle: drive on the falling edge, predict, compare after the rising edge.
  task automatic cyc(input logic ld, input logic [W-1:0] lv, input logic md,
                     input logic [PW-1:0] ps, input logic e, input logic ack);
    exp_t x, got;
    @(negedge C);
    load = ld; load_val = lv; mode = md; prescale = ps; en = e; irq_ack = ack;
    model_step(ld, lv, md, ps, e, ack);
    x = '{cnt: m_cnt, busy: m_run, tick: m_tick, irq: m_irq, ovr: m_ovr};
    exp_q.push_back(x);
    @(posedge C);
    #1;
    cyc_no++;
    if (tick) begin tick_seen++; tick_at.push_back(cyc_no); end
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      got = '{cnt: cnt, busy: busy, tick: tick, irq: irq, ovr: ovr};
      check("cnt",  32'(got.cnt),  32'(x.cnt));
      check("busy", 32'(got.busy), 32'(x.busy));
      check("tick", 32'(got.tick), 32'(x.tick));
      check("irq",  32'(got.irq),  32'(x.irq));
      check("ovr",  32'(got.ovr),  32'(x.ovr));
    end
    $display("cyc %0d ld=%0d lv=%0h md=%0d ps=%0d en=%0d ack=%0d -> cnt=%0h busy=%0d tick=%0d irq=%0d ovr=%0d",
             cyc_no, ld, lv, md, ps, e, ack, cnt, busy, tick, irq, ovr);
  endtask

  initial begin
    int t0, base;

    // Power-up reset
    #2 R_n = 1'b0;
    #1;
    check("rst_cnt",  32'(cnt),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq",  32'(irq),  32'd0);
    model_reset();
    repeat (2) @(negedge C);
    R_n = 1'b1;

    // One-shot, prescale 0, load 3: cnt 3,2,1,0 with a single tick at 0
    t0 = tick_seen;
    cyc(1, 8'd3, 0, 0, 1, 0);
    check("os_load_cnt", 32'(cnt), 32'd3);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    check("os_tick_at_zero", {31'd0, tick}, 32'd1);
    check("os_busy_fall", {31'd0, busy}, 32'd0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    check("os_tick_count", 32'(tick_seen - t0), 32'd1);
    check("os_irq_hold", {31'd0, irq}, 32'd1);

    // Ack in a non-expiry cycle clears both flags
    cyc(0, 0, 0, 0, 1, 1);
    check("ack_clear", {30'd0, irq, ovr}, 32'd0);

    // Periodic, prescale 2, load 2; en gap of 4 cycles; ack coincides with the third tick
    tick_at.delete();
    cyc(1, 8'd2, 1, 8'd2, 1, 0);
    base = cyc_no;
    for (int i = 1; i <= 22; i++)
      cyc(0, 0, 1, 8'd2, !(i >= 13 && i <= 16), (i == 22));
    if (tick_at.size() != 3) begin
      check("per_tick_count", 32'(tick_at.size()), 32'd3);
    end else begin
      check("per_first",  32'(tick_at[0] - base), 32'd6);
      check("per_period", 32'(tick_at[1] - tick_at[0]), 32'd6);
      check("per_gap",    32'(tick_at[2] - tick_at[1]), 32'd10);
    end
    check("ack_with_tick", {30'd0, irq, ovr}, 32'd2);
    cyc(0, 0, 0, 8'd2, 1, 1);

    // Load priority: reload on the would-be expiry cycle, then a zero load
    t0 = tick_seen;
    cyc(1, 8'd2, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 8'd5, 0, 0, 1, 0);
    check("prio_cnt", 32'(cnt), 32'd5);
    check("prio_busy", {31'd0, busy}, 32'd1);
    cyc(1, 8'd0, 0, 0, 1, 0);
    check("zero_load_busy", {31'd0, busy}, 32'd0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    check("prio_no_tick", 32'(tick_seen - t0), 32'd0);

    // Full-width ripple: 8'hFF down to 0
    t0 = tick_seen;
    cyc(1, 8'hFF, 0, 0, 1, 0);
    repeat (258) cyc(0, 0, 0, 0, 1, 0);
    check("wide_tick_count", 32'(tick_seen - t0), 32'd1);

    // Asynchronous reset mid-count
    t0 = tick_seen;
    cyc(1, 8'd10, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    #2 R_n = 1'b0;
    #1;
    check("arst_cnt",  32'(cnt), 32'd0);
    check("arst_flags", {28'd0, busy, tick, irq, ovr}, 32'd0);
    model_reset();
    repeat (2) @(negedge C);
    R_n = 1'b1;
    repeat (15) cyc(0, 0, 0, 0, 1, 0);
    check("arst_no_tick", 32'(tick_seen - t0), 32'd0);
    cyc(1, 8'd1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("post_rst_tick", {31'd0, tick}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
